// File: rtl/kv_port_pkg.sv
// Shared defaults and helpers for the key/value memory port arbiter.
package kv_port_pkg;

   localparam int INDEX_WIDTH_DEF = 8;
   localparam int DATA_WIDTH_DEF  = 64;
   localparam int PE_DEF          = 4;
   localparam int OWNER_W_DEF     = $clog2(PE_DEF);

   typedef struct packed {
      logic                   valid;
      logic [OWNER_W_DEF-1:0] owner;
   } owner_entry_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/port_arbiter_rr_grant.sv
// rr_grant: combinational rotate-priority one-hot grant, search starts at i_ptr and wraps.
module rr_grant
   import kv_port_pkg::*;
#(
   parameter int n  = PE_DEF,
   parameter int pw = idx_w(n)
) (
   input  logic [n-1:0]  i_req,
   input  logic [pw-1:0] i_ptr,
   output logic [n-1:0]  o_gnt,
   output logic [pw-1:0] o_idx,
   output logic          o_any
);

   // first asserted request at or above the pointer wins
   always_comb begin
      logic [pw-1:0] w_j;
      logic          w_hit;
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      w_j   = '0;
      w_hit = 1'b0;
      for (int k = 0; k < n; k++) begin
         w_j        = pw'((int'(i_ptr) + k) % n);
         w_hit      = !o_any && i_req[w_j];
         o_gnt[w_j] = o_gnt[w_j] | w_hit;
         o_idx      = w_hit ? w_j : o_idx;
         o_any      = o_any | w_hit;
      end
   end

endmodule

// File: rtl/port_arbiter.sv
// port_arbiter: round-robin sharing of one key/value memory port with read-response routing.
// Optional PORT_ARB_STATS_EN adds per-engine saturating grant counters on grant_count.
module port_arbiter
   import kv_port_pkg::*;
#(
   parameter int index_width        = INDEX_WIDTH_DEF,
   parameter int data_width         = DATA_WIDTH_DEF,
   parameter int processing_engines = PE_DEF,
   parameter int read_latency       = 2
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [processing_engines-1:0]         req,
   input  logic [processing_engines-1:0]         req_wen,
   input  logic [processing_engines-1:0]         req_ren,
   input  logic [processing_engines*index_width-1:0] req_addr,
   input  logic [processing_engines*data_width-1:0]  req_wdata,
   output logic [processing_engines-1:0]         gnt,
   output logic [index_width-1:0]                port_addr,
   output logic                                  port_wen,
   output logic                                  port_ren,
   output logic [data_width-1:0]                 port_wdata,
   input  logic [data_width-1:0]                 rd_data_in,
   output logic [processing_engines-1:0]         rsp_valid,
   output logic [data_width-1:0]                 rsp_data
`ifdef PORT_ARB_STATS_EN
   ,
   output logic [processing_engines*16-1:0]      grant_count
`endif
);

   localparam int N  = processing_engines;
   localparam int PW = idx_w(N);
   localparam int D  = read_latency + 1;
   localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

   typedef struct packed {
      logic          valid;
      logic [PW-1:0] owner;
   } own_ent_t;

   logic [N-1:0]           w_gnt;
   logic [PW-1:0]          w_idx;
   logic                   w_any;
   logic [index_width-1:0] w_sel_addr;
   logic [data_width-1:0]  w_sel_wdata;
   logic                   w_sel_wen;
   logic                   w_sel_ren;

   logic [PW-1:0]          r_ptr;
   logic [index_width-1:0] r_port_addr;
   logic                   r_port_wen;
   logic                   r_port_ren;
   logic [data_width-1:0]  r_port_wdata;
   logic [N-1:0]           r_rsp_valid;
   logic [data_width-1:0]  r_rsp_data;
   own_ent_t               r_pipe [D];

   rr_grant #(.n(N), .pw(PW)) u_rr_grant (
      .i_req (req),
      .i_ptr (r_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   assign gnt = w_gnt;

   // one-hot mux of the granted engine's request fields
   always_comb begin
      w_sel_addr  = '0;
      w_sel_wdata = '0;
      w_sel_wen   = 1'b0;
      w_sel_ren   = 1'b0;
      for (int i = 0; i < N; i++) begin
         w_sel_addr  = w_sel_addr  | ({index_width{w_gnt[i]}} & req_addr[i*index_width +: index_width]);
         w_sel_wdata = w_sel_wdata | ({data_width{w_gnt[i]}} & req_wdata[i*data_width +: data_width]);
         w_sel_wen   = w_sel_wen   | (w_gnt[i] & req_wen[i]);
         w_sel_ren   = w_sel_ren   | (w_gnt[i] & req_ren[i]);
      end
   end

   // pointer, port registers, owner pipeline and response registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr        <= '0;
         r_port_addr  <= '0;
         r_port_wen   <= 1'b0;
         r_port_ren   <= 1'b0;
         r_port_wdata <= '0;
         r_rsp_valid  <= '0;
         r_rsp_data   <= '0;
         for (int s = 0; s < D; s++) begin
            r_pipe[s] <= '0;
         end
      end else begin
         if (w_any) begin
            r_ptr        <= (w_idx == PW'(N - 1)) ? '0 : w_idx + PW'(1);
            r_port_addr  <= w_sel_addr;
            r_port_wdata <= w_sel_wdata;
         end else begin
            r_ptr        <= r_ptr;
            r_port_addr  <= r_port_addr;
            r_port_wdata <= r_port_wdata;
         end
         r_port_wen <= w_sel_wen;
         r_port_ren <= w_sel_ren;
         // an entry is pushed every cycle so its position encodes elapsed latency
         r_pipe[0] <= '{valid: w_sel_ren, owner: w_idx};
         for (int s = 1; s < D; s++) begin
            r_pipe[s] <= r_pipe[s-1];
         end
         if (r_pipe[D-1].valid) begin
            r_rsp_valid <= ONE_HOT0 << r_pipe[D-1].owner;
            r_rsp_data  <= rd_data_in;
         end else begin
            r_rsp_valid <= '0;
            r_rsp_data  <= r_rsp_data;
         end
      end
   end

   assign port_addr  = r_port_addr;
   assign port_wen   = r_port_wen;
   assign port_ren   = r_port_ren;
   assign port_wdata = r_port_wdata;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_data   = r_rsp_data;

`ifdef PORT_ARB_STATS_EN
   logic [15:0] r_gcnt [N];

   // saturating per-engine grant counters
   always_ff @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (reset) begin
            r_gcnt[i] <= 16'h0000;
         end else if (w_gnt[i] && (r_gcnt[i] != 16'hFFFF)) begin
            r_gcnt[i] <= r_gcnt[i] + 16'h0001;
         end else begin
            r_gcnt[i] <= r_gcnt[i];
         end
      end
   end

   for (genvar g = 0; g < N; g++) begin : g_cnt_out
      assign grant_count[g*16 +: 16] = r_gcnt[g];
   end
`endif

endmodule

// File: tb/tb_port_arbiter.sv
// Directed table-driven bench for port_arbiter (4 engines, read latency 2).
module tb_port_arbiter;

   localparam int N  = 4;
   localparam int IW = 8;
   localparam int DW = 64;
   localparam int L  = 2;

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req, req_wen, req_ren;
   logic [N*IW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N-1:0]    gnt;
   logic [IW-1:0]   port_addr;
   logic            port_wen, port_ren;
   logic [DW-1:0]   port_wdata;
   logic [DW-1:0]   rd_data_in;
   logic [N-1:0]    rsp_valid;
   logic [DW-1:0]   rsp_data;
`ifdef PORT_ARB_STATS_EN
   logic [N*16-1:0] grant_count;
`endif

   int n_vec = 0;
   int n_mis = 0;
   int cur   = 0;

   port_arbiter #(
      .index_width(IW), .data_width(DW), .processing_engines(N), .read_latency(L)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .req_wen    (req_wen),
      .req_ren    (req_ren),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .gnt        (gnt),
      .port_addr  (port_addr),
      .port_wen   (port_wen),
      .port_ren   (port_ren),
      .port_wdata (port_wdata),
      .rd_data_in (rd_data_in),
      .rsp_valid  (rsp_valid),
      .rsp_data   (rsp_data)
`ifdef PORT_ARB_STATS_EN
      ,
      .grant_count(grant_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        rst;
      logic [3:0]  req, wen, ren;
      logic [63:0] rd;
      logic [3:0]  e_gnt;
      logic [7:0]  e_addr;
      logic        e_wen, e_ren;
      logic [63:0] e_wdata;
      logic [3:0]  e_rv;
      logic [63:0] e_rd;
   } vec_t;

   function automatic vec_t mk(input logic rst, input logic [3:0] rq, input logic [3:0] wn,
                               input logic [3:0] rn, input logic [63:0] rd, input logic [3:0] g,
                               input logic [7:0] a, input logic we, input logic re,
                               input logic [63:0] wd, input logic [3:0] rv, input logic [63:0] rsd);
      vec_t v;
      v = '{rst, rq, wn, rn, rd, g, a, we, re, wd, rv, rsd};
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s step %0d: got %h, expected %h", nm, cur, act, exp);
      end
   endtask

   vec_t vt [25];

   initial begin
      for (int i = 0; i < N; i++) begin
         req_addr[i*IW +: IW]  = 8'(16 * (i + 1));
         req_wdata[i*DW +: DW] = 64'hA5 + 64'(i) * 64'h100;
      end
      reset = 1'b1; req = '0; req_wen = '0; req_ren = '0; rd_data_in = '0;

      //          rst   req    wen    ren    rd_data     gnt   addr   we    re    wdata     rv     rsp_data
      vt[0]  = mk(1'b1, 4'h0, 4'h0, 4'h0, 64'h0,      4'h0, 8'h00, 1'b0, 1'b0, 64'h0,   4'h0, 64'h0);
      vt[1]  = mk(1'b0, 4'h1, 4'h1, 4'h0, 64'h0,      4'h1, 8'h10, 1'b1, 1'b0, 64'hA5,  4'h0, 64'h0);
      vt[2]  = mk(1'b0, 4'hF, 4'h0, 4'h0, 64'h0,      4'h2, 8'h20, 1'b0, 1'b0, 64'h1A5, 4'h0, 64'h0);
      vt[3]  = mk(1'b0, 4'hF, 4'h0, 4'h0, 64'h0,      4'h4, 8'h30, 1'b0, 1'b0, 64'h2A5, 4'h0, 64'h0);
      vt[4]  = mk(1'b0, 4'hF, 4'h0, 4'h0, 64'h0,      4'h8, 8'h40, 1'b0, 1'b0, 64'h3A5, 4'h0, 64'h0);
      vt[5]  = mk(1'b0, 4'hF, 4'h0, 4'h0, 64'h0,      4'h1, 8'h10, 1'b0, 1'b0, 64'hA5,  4'h0, 64'h0);
      vt[6]  = mk(1'b0, 4'h4, 4'h0, 4'h4, 64'h0,      4'h4, 8'h30, 1'b0, 1'b1, 64'h2A5, 4'h0, 64'h0);
      vt[7]  = mk(1'b0, 4'h0, 4'h0, 4'h0, 64'h0,      4'h0, 8'h30, 1'b0, 1'b0, 64'h2A5, 4'h0, 64'h0);
      vt[8]  = mk(1'b0, 4'h0, 4'h0, 4'h0, 64'h0,      4'h0, 8'h30, 1'b0, 1'b0, 64'h2A5, 4'h0, 64'h0);
      vt[9]  = mk(1'b0, 4'h0, 4'h0, 4'h0, 64'hDEAD,   4'h0, 8'h30, 1'b0, 1'b0, 64'h2A5, 4'h4, 64'hDEAD);
      vt[10] = mk(1'b0, 4'h0, 4'h0, 4'h0, 64'h1234,   4'h0, 8'h30, 1'b0, 1'b0, 64'h2A5, 4'h0, 64'hDEAD);
      vt[11] = mk(1'b0, 4'h2, 4'h0, 4'h2, 64'h0,      4'h2, 8'h20, 1'b0, 1'b1, 64'h1A5, 4'h0, 64'hDEAD);
      vt[12] = mk(1'b0, 4'h8, 4'h0, 4'h8, 64'h0,      4'h8, 8'h40, 1'b0, 1'b1, 64'h3A5, 4'h0, 64'hDEAD);
      vt[13] = mk(1'b0, 4'h0, 4'h0, 4'h0, 64'h0,      4'h0, 8'h40, 1'b0, 1'b0, 64'h3A5, 4'h0, 64'hDEAD);
      vt[14] = mk(1'b0, 4'h0, 4'h0, 4'h0, 64'h1111,   4'h0, 8'h40, 1'b0, 1'b0, 64'h3A5, 4'h2, 64'h1111);
      vt[15] = mk(1'b0, 4'h0, 4'h0, 4'h0, 64'h3333,   4'h0, 8'h40, 1'b0, 1'b0, 64'h3A5, 4'h8, 64'h3333);
      vt[16] = mk(1'b0, 4'h0, 4'h0, 4'h0, 64'h0,      4'h0, 8'h40, 1'b0, 1'b0, 64'h3A5, 4'h0, 64'h3333);
      vt[17] = mk(1'b0, 4'h1, 4'h1, 4'h1, 64'h0,      4'h1, 8'h10, 1'b1, 1'b1, 64'hA5,  4'h0, 64'h3333);
      vt[18] = mk(1'b0, 4'h4, 4'h0, 4'h4, 64'h0,      4'h4, 8'h30, 1'b0, 1'b1, 64'h2A5, 4'h0, 64'h3333);
      vt[19] = mk(1'b1, 4'h8, 4'h0, 4'h8, 64'h0,      4'h8, 8'h00, 1'b0, 1'b0, 64'h0,   4'h0, 64'h0);
      vt[20] = mk(1'b0, 4'h0, 4'h0, 4'h0, 64'hBEEF,   4'h0, 8'h00, 1'b0, 1'b0, 64'h0,   4'h0, 64'h0);
      vt[21] = mk(1'b0, 4'h0, 4'h0, 4'h0, 64'hBEEF,   4'h0, 8'h00, 1'b0, 1'b0, 64'h0,   4'h0, 64'h0);
      vt[22] = mk(1'b0, 4'h9, 4'h9, 4'h0, 64'h0,      4'h1, 8'h10, 1'b1, 1'b0, 64'hA5,  4'h0, 64'h0);
      vt[23] = mk(1'b0, 4'h9, 4'h9, 4'h0, 64'h0,      4'h8, 8'h40, 1'b1, 1'b0, 64'h3A5, 4'h0, 64'h0);
      vt[24] = mk(1'b0, 4'h0, 4'h0, 4'h0, 64'hBEEF,   4'h0, 8'h40, 1'b0, 1'b0, 64'h3A5, 4'h0, 64'h0);

      for (int v = 0; v < 25; v++) begin
         cur = v;
         @(negedge clk);
         reset = vt[v].rst; req = vt[v].req; req_wen = vt[v].wen; req_ren = vt[v].ren;
         rd_data_in = vt[v].rd;
         #1;
         n_vec++;
         chk("gnt", 64'(gnt), 64'(vt[v].e_gnt));
         @(posedge clk);
         #1;
         chk("port_addr",  64'(port_addr), 64'(vt[v].e_addr));
         chk("port_wen",   64'(port_wen),  64'(vt[v].e_wen));
         chk("port_ren",   64'(port_ren),  64'(vt[v].e_ren));
         chk("port_wdata", port_wdata,     vt[v].e_wdata);
         chk("rsp_valid",  64'(rsp_valid), 64'(vt[v].e_rv));
         chk("rsp_data",   rsp_data,       vt[v].e_rd);
      end

      // back-to-back reads from all engines: no gaps, responses in grant order
      for (int k = 0; k < 12; k++) begin
         logic [3:0] eg, erv;
         cur = 100 + k;
         @(negedge clk);
         req = (k < 8) ? 4'hF : 4'h0; req_ren = req; req_wen = 4'h0;
         rd_data_in = 64'hC000 + 64'(k);
         eg  = (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000;
         erv = (k >= 3 && k < 11) ? (4'b0001 << ((k - 3) % 4)) : 4'b0000;
         #1;
         n_vec++;
         chk("rr_gnt", 64'(gnt), 64'(eg));
         @(posedge clk);
         #1;
         chk("rr_port_ren", 64'(port_ren), 64'(k < 8));
         chk("rr_rsp_valid", 64'(rsp_valid), 64'(erv));
         if (erv != 4'b0000) chk("rr_rsp_data", rsp_data, 64'hC000 + 64'(k));
      end

`ifdef PORT_ARB_STATS_EN
      @(negedge clk);
      reset = 1'b1; req = '0; req_ren = '0;
      @(negedge clk);
      reset = 1'b0; req = 4'h1; req_wen = 4'h1;
      repeat (70000) @(negedge clk);
      req = '0; req_wen = '0;
      #1;
      cur = 200;
      n_vec++;
      chk("grant_count", 64'(grant_count), 64'h0000_0000_0000_FFFF);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/port_arbiter.md
# port_arbiter

Round-robin arbiter that shares one key/value memory port among `processing_engines` requesters. Accepts per-engine read/write requests, grants one per cycle, and drives the registered port signals (`addr`, `wen`, `ren`, write data) that feed the port pipeline register. It tracks which engine owns each in-flight read and routes returning read data back to that engine after a fixed memory latency.

## Interface
- `index_width`, 8, address width
- `data_width`, 64, key/value word width
- `processing_engines`, 4, number of requesters (N), ≥2
- `read_latency`, 2, cycles from port outputs to `rd_data_in` valid, ≥1
- `clk` in 1 — single clock, all logic on posedge
- `reset` in 1 — synchronous, active-high
- `req` in N — per-engine request valid
- `req_wen` in N — per-engine write enable
- `req_ren` in N — per-engine read enable
- `req_addr` in N*index_width — flattened, engine i at `[i*index_width +: index_width]`
- `req_wdata` in N*data_width — flattened write key/value
- `gnt` out N — one-hot grant, combinational from `req` and pointer
- `port_addr` out index_width — registered address to port register
- `port_wen` out 1 — registered write enable
- `port_ren` out 1 — registered read enable
- `port_wdata` out data_width — registered write key/value
- `rd_data_in` in data_width — read data returning from memory
- `rsp_valid` out N — one-hot, registered read-response valid
- `rsp_data` out data_width — registered read data, broadcast to all engines

## Operation
- Transfer occurs when `req[i] & gnt[i]`; an engine holds `req` and its fields stable until granted.
- Arbitration: round-robin; search starts at pointer `ptr`, first asserted `req` at or above `ptr` (wrapping) wins. After a grant to i, `ptr` ← (i+1) mod N. No grant → `ptr` unchanged.
- `req[i]` with neither `req_wen` nor `req_ren`: still granted, issues a no-op (port enables 0), consumes the slot.
- `req_wen` and `req_ren` both set: single slot, both enables issued same cycle; read returns pre-write data (memory read-first semantics).
- Owner pipeline: shift register depth `read_latency+1` of {valid, owner index}; entry pushed on every cycle (valid = granted read).
- At the pipeline tail, valid entry → `rsp_valid[owner]`=1 and `rsp_data` ← `rd_data_in` next cycle; otherwise `rsp_valid`=0, `rsp_data` holds.
- No backpressure on responses; engines must accept `rsp_valid` the cycle it is high.

## Timing
- Reset values: `port_addr`=0, `port_wen`=0, `port_ren`=0, `port_wdata`=0, `rsp_valid`=0, `rsp_data`=0, `ptr`=0, owner pipeline all invalid. `gnt` follows `req` combinationally even in reset cycle but no transfer is recorded while `reset`=1.
- Grant in cycle T → port outputs valid in T+1 → `rd_data_in` sampled in T+1+`read_latency` → `rsp_valid` high in T+2+`read_latency`.
- Throughput: one transfer per cycle, back-to-back from any mix of engines.
- Reset mid-operation: all in-flight reads dropped, no `rsp_valid` for them; `ptr` returns to 0.
- Wrap: grant to engine N-1 sets `ptr`=0.

## Configuration
- `PORT_ARB_STATS_EN`: defined → adds per-engine 16-bit saturating grant counters (hold at 16'hFFFF) and output `grant_count` (N*16, flattened), cleared by `reset`. Undefined → counters and port absent; arbitration unchanged.

## Structure
- Shared package `kv_port_pkg`: `index_width`/`data_width` defaults, owner-entry typedef {valid, owner index of width $clog2(N)}.
- One sub-module: `rr_grant` — combinational rotate-priority one-hot grant from `req` and `ptr`; top holds pointer, port registers, owner pipeline.

## Test plan
- Reset then single write: `req`=4'b0001, `req_wen`[0]=1, addr 8'h10, data 64'hA5 → `gnt`=0001 same cycle; next cycle `port_wen`=1, `port_addr`=8'h10, `port_wdata`=64'hA5.
- All four request continuously from `ptr`=0 → grants 0,1,2,3,0 on consecutive cycles, no gaps.
- Read by engine 2 at T, `rd_data_in`=64'hDEAD at T+3 (latency 2) → `rsp_valid`=0100, `rsp_data`=64'hDEAD at T+4; other engines' `rsp_valid` 0.
- Back-to-back reads from engines 1 then 3 → responses on consecutive cycles with correct one-hot owners.
- Reads in flight, `reset` pulsed one cycle → no `rsp_valid` afterwards; next grant starts at engine 0.
- `PORT_ARB_STATS_EN` defined: 70000 grants to engine 0 → `grant_count[0]`=16'hFFFF, others 0.
